// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/load sequencer for the mm:ss countdown datapath.
// Owns the 1 Hz prescaler and the control FSM. It drives the count enables, the
// load strobe, the mode and empty flags into the seconds/minutes down-counters,
// and uses their zero flags to decide minute borrows and end-of-count.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   start_pulse  in   one-cycle start/pause toggle request
//   load_pulse   in   one-cycle load-initial-value request
//   set_mode     in   level, 1 = user is editing init values
//   sec_zero     in   seconds counter == 0
//   min_zero     in   minutes counter == 0
//   sec_count_en out  decrement strobe to seconds counter
//   min_count_en out  decrement strobe to minutes counter (borrow)
//   load_n       out  active-low load strobe to both counters (registered)
//   cnt_mode     out  1 = counters track init values (registered)
//   empty        out  1 = seconds must not wrap 0 -> 59
//   running      out  state == RUN
//   done         out  state == DONE
//   state        out  FSM state code, for debug
module countdown_ctrl #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned PW       = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic       load_pulse,
    input  logic       set_mode,
    input  logic       sec_zero,
    input  logic       min_zero,
    output logic       sec_count_en,
    output logic       min_count_en,
    output logic       load_n,
    output logic       cnt_mode,
    output logic       empty,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StPause = 3'd2,
        StDone  = 3'd3,
        StSetup = 3'd4
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_next;
    logic            r_load_n;
    logic            r_cnt_mode;
    logic            w_presc_max;
    logic            w_tick;
    logic            w_both_zero;
    logic            w_load_acc;

    always_comb begin
        w_presc_max  = (r_presc == PW'(TICK_DIV - 1));
        w_tick       = (r_state == StRun) & w_presc_max;
        w_both_zero  = sec_zero & min_zero;
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_load_acc   = 1'b0;

        // Priority within a cycle: load_pulse, then set_mode, then start_pulse.
        case (r_state)
            StIdle: begin
                if (load_pulse) begin
                    w_load_acc = 1'b1;
                end else if (set_mode) begin
                    w_state_next = StSetup;
                end else if (start_pulse && !w_both_zero) begin
                    w_state_next = StRun;
                    w_presc_next = '0;
                end
            end
            StRun: begin
                w_presc_next = w_presc_max ? '0 : r_presc + PW'(1);
                if (start_pulse) begin
                    w_state_next = StPause;
                end else if (w_tick && w_both_zero) begin
                    w_state_next = StDone;
                end
            end
            StPause: begin
                // Resuming keeps the held prescaler phase.
                if (load_pulse) begin
                    w_load_acc   = 1'b1;
                    w_state_next = StIdle;
                end else if (set_mode) begin
                    w_state_next = StSetup;
                end else if (start_pulse) begin
                    w_state_next = StRun;
                end
            end
            StDone: begin
                if (load_pulse) begin
                    w_load_acc   = 1'b1;
                    w_state_next = StIdle;
                end else if (set_mode) begin
                    w_state_next = StSetup;
                end else if (start_pulse) begin
                    w_state_next = StIdle;
                end
            end
            StSetup: begin
                if (!set_mode) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_presc_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_presc    <= '0;
            r_load_n   <= 1'b1;
            r_cnt_mode <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_presc    <= w_presc_next;
            r_load_n   <= ~w_load_acc;
            r_cnt_mode <= (w_state_next == StSetup);
        end
    end

    // An accepted load always lands in IDLE, so no tick can coincide with load_n low.
    assign sec_count_en = w_tick;
    assign min_count_en = w_tick & sec_zero & ~min_zero;
    assign load_n       = r_load_n;
    assign cnt_mode     = r_cnt_mode;
    assign empty        = min_zero;
    assign running      = (r_state == StRun);
    assign done         = (r_state == StDone);
    assign state        = r_state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with TICK_DIV=4. A behavioural mm:ss counter pair
// is driven from the DUT outputs and feeds the zero flags back. A reference
// model tracks mode and the number of RUN cycles since launch to predict outputs.
module tb_countdown_ctrl;

    localparam int unsigned TD  = 4;
    localparam int unsigned PWT = 3;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;
    localparam int S_SETUP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_pulse = 1'b0;
    logic       load_pulse = 1'b0;
    logic       set_mode = 1'b0;
    logic       sec_zero = 1'b1;
    logic       min_zero = 1'b1;
    logic       sec_count_en;
    logic       min_count_en;
    logic       load_n;
    logic       cnt_mode;
    logic       empty;
    logic       running;
    logic       done;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    // Counter pair model and its init values.
    int cm = 0, cs = 0, init_m = 0, init_s = 0;
    // Reference model: mode, RUN cycles since launch, pending load strobe.
    int mst = S_IDLE, mphase = 0;
    bit mload_low = 1'b0;
    // Last observed DUT outputs and pulse tallies.
    bit obs_sec_en, obs_min_en, obs_load_n, obs_cnt_mode;
    int sec_pulses = 0, min_pulses = 0;

    countdown_ctrl #(.TICK_DIV(TD), .PW(PWT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_pulse  (start_pulse),
        .load_pulse   (load_pulse),
        .set_mode     (set_mode),
        .sec_zero     (sec_zero),
        .min_zero     (min_zero),
        .sec_count_en (sec_count_en),
        .min_count_en (min_count_en),
        .load_n       (load_n),
        .cnt_mode     (cnt_mode),
        .empty        (empty),
        .running      (running),
        .done         (done),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check at negedge, advance models.
    task automatic step(input bit st, input bit ld, input bit sm);
        bit tick, sz, mz;
        int nst;
        start_pulse = st;
        load_pulse  = ld;
        set_mode    = sm;
        sz = (cs == 0);
        mz = (cm == 0);
        sec_zero = sz;
        min_zero = mz;
        @(negedge clk);
        tick = (mst == S_RUN) && ((mphase % TD) == TD - 1);
        chk("state", 32'(state), 32'(mst));
        chk("running", 32'(running), 32'(mst == S_RUN));
        chk("done", 32'(done), 32'(mst == S_DONE));
        chk("load_n", 32'(load_n), 32'(!mload_low));
        chk("cnt_mode", 32'(cnt_mode), 32'(mst == S_SETUP));
        chk("sec_count_en", 32'(sec_count_en), 32'(tick));
        chk("min_count_en", 32'(min_count_en), 32'(tick && sz && !mz));
        chk("empty", 32'(empty), 32'(mz));
        obs_sec_en   = sec_count_en;
        obs_min_en   = min_count_en;
        obs_load_n   = load_n;
        obs_cnt_mode = cnt_mode;
        if (sec_count_en) sec_pulses++;
        if (min_count_en) min_pulses++;
        // Counters react to what the DUT actually drives.
        if (!load_n || cnt_mode) begin
            cm = init_m;
            cs = init_s;
        end else begin
            if (sec_count_en) cs = (cs == 0) ? (empty ? 0 : 59) : cs - 1;
            if (min_count_en && cm > 0) cm--;
        end
        mload_low = 1'b0;
        nst = mst;
        case (mst)
            S_IDLE: begin
                if (ld) mload_low = 1'b1;
                else if (sm) nst = S_SETUP;
                else if (st && !(sz && mz)) begin
                    nst = S_RUN;
                    mphase = 0;
                end
            end
            S_RUN: begin
                mphase++;
                if (st) nst = S_PAUSE;
                else if (tick && sz && mz) nst = S_DONE;
            end
            S_PAUSE, S_DONE: begin
                if (ld) begin
                    mload_low = 1'b1;
                    nst = S_IDLE;
                end else if (sm) nst = S_SETUP;
                else if (st) nst = (mst == S_PAUSE) ? S_RUN : S_IDLE;
            end
            S_SETUP: if (!sm) nst = S_IDLE;
            default: nst = S_IDLE;
        endcase
        mst = nst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_load_n", 32'(load_n), 32'd1);
        chk("rst_sec_en", 32'(sec_count_en), 32'd0);
        chk("rst_min_en", 32'(min_count_en), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cnt_mode", 32'(cnt_mode), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mst = S_IDLE;
        mphase = 0;
        mload_low = 1'b0;
    endtask

    task automatic load_init(input int m, input int s);
        init_m = m;
        init_s = s;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end while (!obs_sec_en && n < 20);
    endtask

    task automatic run_to_done(input int bound, output int used);
        used = 0;
        while (mst != S_DONE && used < bound) begin
            step(1'b0, 1'b0, 1'b0);
            used++;
        end
    endtask

    initial begin
        int n, used, p0;
        bit sm_lvl;
        #1;
        do_reset();

        // 1: reset in RUN mid-prescale, then idle without start.
        load_init(0, 5);
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("rst_hold_state", 32'(state), 32'd0);

        // 2: 1:02 countdown to DONE.
        load_init(1, 2);
        sec_pulses = 0;
        min_pulses = 0;
        step(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        chk("first_tick_latency", 32'(n), 32'd4);
        run_to_done(400, used);
        chk("done_in_budget", 32'(used < 400), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_done_out", 32'(done), 32'd1);
        chk("t2_sec_pulses", 32'(sec_pulses), 32'd63);
        chk("t2_min_pulses", 32'(min_pulses), 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("t2_min_final", 32'(cm), 32'd0);
        chk("t2_sec_final", 32'(cs), 32'd0);

        // 3: pause with presc held at 2, resume, tick on 2nd RUN cycle.
        load_init(0, 30);
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        p0 = sec_pulses;
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("t3_no_tick_paused", 32'(sec_pulses - p0), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        chk("t3_resume_latency", 32'(n), 32'd2);

        // 4: start and load together in IDLE.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        p0 = sec_pulses;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_load_n_low", 32'(obs_load_n), 32'd0);
        chk("t4_state_idle", 32'(state), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_load_n_high", 32'(obs_load_n), 32'd1);
        chk("t4_no_enables", 32'(sec_pulses - p0), 32'd0);

        // 5: set_mode ignored in RUN; PAUSE -> SETUP -> IDLE.
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1);
        chk("t5_still_running", 32'(running), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_cnt_mode", 32'(obs_cnt_mode), 32'd1);
        chk("t5_setup_state", 32'(state), 32'd4);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_idle_state", 32'(state), 32'd0);

        // 6: start ignored at 0:00; DONE -> IDLE on start.
        load_init(0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_idle_at_zero", 32'(state), 32'd0);
        chk("t6_not_done", 32'(done), 32'd0);
        load_init(0, 1);
        step(1'b1, 1'b0, 1'b0);
        run_to_done(50, used);
        chk("t6_done_in_budget", 32'(used < 50), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_idle_after_done", 32'(state), 32'd0);
        chk("t6_done_cleared", 32'(done), 32'd0);

        // Randomised traffic against the reference model.
        sm_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                init_m = $urandom_range(0, 1);
                init_s = $urandom_range(0, 5);
            end
            if ($urandom_range(0, 30) == 0) sm_lvl = ~sm_lvl;
            step($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0, sm_lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
